// File: rtl/wb_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// wb_bus_arbiter_if : bundles the two CPU-side master ports and the shared
//                     memory-side port of wb_bus_arbiter.
// Revision : 1.0
// ============================================================================
interface wb_bus_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int SW = 4
);
  logic          m0_stb_i;
  logic [AW-1:0] m0_adr_i;
  logic [DW-1:0] m0_dat_o;
  logic          m0_ack_o;
  logic          m0_err_o;

  logic          m1_stb_i;
  logic          m1_we_i;
  logic [SW-1:0] m1_sel_i;
  logic [AW-1:0] m1_adr_i;
  logic [DW-1:0] m1_dat_i;
  logic [DW-1:0] m1_dat_o;
  logic          m1_ack_o;
  logic          m1_err_o;

  logic          s_cyc_o;
  logic          s_stb_o;
  logic          s_we_o;
  logic [SW-1:0] s_sel_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic [DW-1:0] s_dat_i;
  logic          s_ack_i;

  // Arbiter view: slave to both CPU masters, driver of the memory port.
  modport slave (
    input  m0_stb_i, m0_adr_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    input  s_dat_i, s_ack_i
  );

  // Surrounding-system view: CPU masters and memory model.
  modport master (
    output m0_stb_i, m0_adr_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    output m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    output s_dat_i, s_ack_i
  );
endinterface
`default_nettype wire

// File: rtl/wb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// wb_bus_arbiter : round-robin Wishbone arbiter, fetch (M0) and load/store (M1)
//                  masters onto one memory slave. Optional macro:
//                  WB_ARB_TIMEOUT_EN (abort with mx_err_o after TIMEOUT cycles).
// Revision : 1.0
// ============================================================================
module wb_bus_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int SW      = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  wb_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;   // 0: M0 granted last, 1: M1 granted last

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_hit;

  assign timeout_hit = (state_q != IDLE) && (cnt_q == CW'(TIMEOUT - 1));

  // Every grant is entered from IDLE, so clearing there restarts the count.
  always_comb begin
    cnt_d = '0;
    if ((state_q != IDLE) && !bus.s_ack_i && !timeout_hit) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
`endif

  assign bus.m0_dat_o = bus.s_dat_i;
  assign bus.m1_dat_o = bus.s_dat_i;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    bus.s_cyc_o  = 1'b0;
    bus.s_stb_o  = 1'b0;
    bus.s_we_o   = 1'b0;
    bus.s_sel_o  = {SW{1'b0}};
    bus.s_adr_o  = {AW{1'b0}};
    bus.s_dat_o  = {DW{1'b0}};
    bus.m0_ack_o = 1'b0;
    bus.m1_ack_o = 1'b0;
    bus.m0_err_o = 1'b0;
    bus.m1_err_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.m0_stb_i && (!bus.m1_stb_i || last_q)) begin
          state_d = GNT0;
        end else if (bus.m1_stb_i) begin
          state_d = GNT1;
        end
      end

      GNT0: begin
        bus.s_cyc_o = 1'b1;
        bus.s_stb_o = bus.m0_stb_i;
        bus.s_sel_o = {SW{1'b1}};
        bus.s_adr_o = bus.m0_adr_i;
        if (!bus.m0_stb_i) begin
          state_d = IDLE;
        end else if (bus.s_ack_i) begin
          bus.m0_ack_o = 1'b1;
          last_d       = 1'b0;
          state_d      = IDLE;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          bus.m0_err_o = 1'b1;
          last_d       = 1'b0;
          state_d      = IDLE;
        end
`endif
      end

      GNT1: begin
        bus.s_cyc_o = 1'b1;
        bus.s_stb_o = bus.m1_stb_i;
        bus.s_we_o  = bus.m1_we_i;
        bus.s_sel_o = bus.m1_sel_i;
        bus.s_adr_o = bus.m1_adr_i;
        bus.s_dat_o = bus.m1_dat_i;
        if (!bus.m1_stb_i) begin
          state_d = IDLE;
        end else if (bus.s_ack_i) begin
          bus.m1_ack_o = 1'b1;
          last_d       = 1'b1;
          state_d      = IDLE;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          bus.m1_err_o = 1'b1;
          last_d       = 1'b1;
          state_d      = IDLE;
        end
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_wb_bus_arbiter : directed self-checking bench for wb_bus_arbiter.
// Revision : 1.0
// ============================================================================
module tb_wb_bus_arbiter;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   bad;

  wb_bus_arbiter_if #(.AW(16), .DW(16), .SW(4)) bus ();

  wb_bus_arbiter #(
    .AW(16), .DW(16), .SW(4), .TIMEOUT(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    #0;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.m0_stb_i = 1'b0; bus.m0_adr_i = '0;
    bus.m1_stb_i = 1'b0; bus.m1_we_i = 1'b0; bus.m1_sel_i = '0;
    bus.m1_adr_i = '0;   bus.m1_dat_i = '0;
    bus.s_dat_i  = '0;   bus.s_ack_i  = 1'b0;

    // Reset state
    step(); step();
    #1;
    chk("rst_cyc",  bus.s_cyc_o,  0);
    chk("rst_stb",  bus.s_stb_o,  0);
    chk("rst_adr",  bus.s_adr_o,  0);
    chk("rst_sel",  bus.s_sel_o,  0);
    chk("rst_acks", {bus.m0_ack_o, bus.m1_ack_o, bus.m0_err_o, bus.m1_err_o}, 0);
    rst = 1'b0;
    step(); step(); step();
    #1;
    chk("idle_cyc", bus.s_cyc_o, 0);

    // Single M0 fetch, slave acks two cycles after strobe
    bus.m0_stb_i = 1'b1; bus.m0_adr_i = 16'h0010;
    #1;
    chk("lat_cyc", bus.s_cyc_o, 0);
    step();
    #1;
    chk("m0_cyc", bus.s_cyc_o, 1);
    chk("m0_stb", bus.s_stb_o, 1);
    chk("m0_adr", bus.s_adr_o, 16'h0010);
    chk("m0_we",  bus.s_we_o,  0);
    chk("m0_sel", bus.s_sel_o, 4'hF);
    step(); step();
    bus.s_ack_i = 1'b1; bus.s_dat_i = 16'hA5A5;
    #1;
    chk("m0_ack",     bus.m0_ack_o, 1);
    chk("m0_dat",     bus.m0_dat_o, 16'hA5A5);
    chk("m0_no_m1ak", bus.m1_ack_o, 0);
    step();
    bus.s_ack_i = 1'b0; bus.m0_stb_i = 1'b0;
    #1;
    chk("post_idle", bus.s_cyc_o, 0);
    chk("post_ack",  bus.m0_ack_o, 0);

    // Simultaneous requests after reset: M0 first, then alternate
    rst = 1'b1; step(); rst = 1'b0;
    bus.m0_stb_i = 1'b1; bus.m0_adr_i = 16'h0020;
    bus.m1_stb_i = 1'b1; bus.m1_we_i = 1'b1; bus.m1_sel_i = 4'hF;
    bus.m1_adr_i = 16'h0200; bus.m1_dat_i = 16'h1234;
    step();
    #1;
    chk("tie_first_adr", bus.s_adr_o, 16'h0020);
    chk("tie_first_we",  bus.s_we_o,  0);
    bus.s_ack_i = 1'b1; bus.s_dat_i = 16'h1111;
    #1;
    chk("tie_m0_ack", {bus.m0_ack_o, bus.m1_ack_o}, 2'b10);
    step();
    bus.s_ack_i = 1'b0;
    #1;
    chk("tie_gap_cyc", bus.s_cyc_o, 0);
    step();
    #1;
    chk("tie_m1_cyc", bus.s_cyc_o, 1);
    chk("tie_m1_adr", bus.s_adr_o, 16'h0200);
    chk("tie_m1_we",  bus.s_we_o,  1);
    chk("tie_m1_sel", bus.s_sel_o, 4'hF);
    chk("tie_m1_dat", bus.s_dat_o, 16'h1234);
    bus.s_ack_i = 1'b1; bus.s_dat_i = 16'hBEEF;
    #1;
    chk("tie_m1_ack", {bus.m0_ack_o, bus.m1_ack_o}, 2'b01);
    chk("tie_m1_rd",  bus.m1_dat_o, 16'hBEEF);
    step();
    bus.s_ack_i = 1'b0;
    step();
    #1;
    chk("alt_m0_adr", bus.s_adr_o, 16'h0020);
    bus.s_ack_i = 1'b1;
    #1;
    chk("alt_m0_ack", bus.m0_ack_o, 1);
    step();
    bus.s_ack_i = 1'b0; bus.m0_stb_i = 1'b0; bus.m1_stb_i = 1'b0;

    // M1 abandons its request; pending M0 granted afterwards
    bus.m1_stb_i = 1'b1;
    step();
    #1;
    chk("ab_m1_cyc", bus.s_cyc_o, 1);
    bus.m0_stb_i = 1'b1; bus.m0_adr_i = 16'h0030;
    step();
    #1;
    chk("ab_nopreempt", bus.s_adr_o, 16'h0200);
    bus.m1_stb_i = 1'b0;
    #1;
    chk("ab_stb_drop", bus.s_stb_o, 0);
    chk("ab_no_ack",   bus.m1_ack_o, 0);
    step();
    #1;
    chk("ab_idle",     bus.s_cyc_o, 0);
    chk("ab_idle_ack", bus.m1_ack_o, 0);
    step();
    #1;
    chk("ab_m0_adr", bus.s_adr_o, 16'h0030);
    bus.s_ack_i = 1'b1;
    #1;
    chk("ab_m0_ack", bus.m0_ack_o, 1);
    step();
    bus.s_ack_i = 1'b0; bus.m0_stb_i = 1'b0;

    // Reset while M1 waits; a late ack must not reach anyone
    bus.m1_stb_i = 1'b1;
    step();
    #1;
    chk("rs_cyc", bus.s_cyc_o, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rs_cyc_off", bus.s_cyc_o, 0);
    bus.m1_stb_i = 1'b0; bus.s_ack_i = 1'b1;
    #1;
    chk("rs_late_ack", {bus.m0_ack_o, bus.m1_ack_o}, 2'b00);
    step();
    #1;
    chk("rs_stay_idle", bus.s_cyc_o, 0);
    bus.s_ack_i = 1'b0;

    // Silent slave
    bus.m0_stb_i = 1'b1; bus.m0_adr_i = 16'h0040;
    step();
`ifdef WB_ARB_TIMEOUT_EN
    for (int i = 1; i <= 15; i++) begin
      #1;
      chk("to_no_err", {bus.s_cyc_o, bus.m0_err_o}, 2'b10);
      step();
    end
    #1;
    chk("to_err",    {bus.m0_err_o, bus.m1_err_o, bus.m0_ack_o}, 3'b100);
    step();
    bus.m0_stb_i = 1'b0;
    #1;
    chk("to_idle",   bus.s_cyc_o, 0);
    chk("to_err_off", bus.m0_err_o, 0);
`else
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (bus.s_cyc_o !== 1'b1 || bus.m0_err_o !== 1'b0) bad++;
      step();
    end
    chk("hold_100", bad, 0);
    chk("hold_cyc", bus.s_cyc_o, 1);
    bus.s_ack_i = 1'b1;
    #1;
    chk("hold_ack", bus.m0_ack_o, 1);
    step();
    bus.s_ack_i = 1'b0; bus.m0_stb_i = 1'b0;
    #1;
    chk("hold_idle", bus.s_cyc_o, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
